// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared types for the IF/D memory port arbiter
package proc_pkg;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_D  = 1'b1
   } mem_owner_t;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_HOLD_IF = 2'd1,
      ARB_HOLD_D  = 2'd2
   } arb_state_t;

   typedef struct packed {
      mem_owner_t owner;
      logic       discard;
   } owner_entry_t;

endpackage

// File: rtl/mem_owner_fifo.sv
// rtl/mem_owner_fifo.sv - in-order owner/discard tracking for outstanding memory transactions
module mem_owner_fifo
   import proc_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic push_i,
   input  logic push_owner_d_i,
   input  logic push_discard_i,
   input  logic pop_i,
   input  logic flush_i,
   output logic head_owner_d_o,
   output logic head_discard_o,
   output logic empty_o,
   output logic full_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   owner_entry_t  entries [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty_o        = (count == '0);
   assign full_o         = (count == CW'(DEPTH));
   assign do_pop         = pop_i & ~empty_o;
   assign do_push        = push_i & ~full_o;
   assign head_owner_d_o = (entries[rd_ptr].owner == OWNER_D);
   assign head_discard_o = entries[rd_ptr].discard;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '{owner: OWNER_IF, discard: 1'b0};
         end
      end else begin
         // Stale slots may be marked too; they are overwritten before they are read again.
         if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (entries[i].owner == OWNER_IF) begin
                  entries[i].discard <= 1'b1;
               end
            end
         end
         if (do_push) begin
            entries[wr_ptr] <= '{owner: push_owner_d_i ? OWNER_D : OWNER_IF,
                                 discard: push_discard_i};
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (do_push != do_pop) begin
            count <= do_push ? count + CW'(1) : count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/D arbiter onto a single-port memory bus with in-order response routing
module mem_port_arbiter
   import proc_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4,
   parameter int AW              = 32,
   parameter int DW              = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic            if_req_i,
   input  logic [AW-1:0]   if_addr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [DW-1:0]   if_rdata_o,
   input  logic            d_req_i,
   input  logic            d_we_i,
   input  logic [DW/8-1:0] d_be_i,
   input  logic [AW-1:0]   d_addr_i,
   input  logic [DW-1:0]   d_wdata_i,
   output logic            d_gnt_o,
   output logic            d_rvalid_o,
   output logic [DW-1:0]   d_rdata_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [DW/8-1:0] mem_be_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [DW-1:0]   mem_rdata_i
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   arb_state_t    state_q;
   arb_state_t    state_d;
   logic [SW-1:0] starve_q;
   logic          starved;
   logic          sel_is_d;
   logic          req_pend;
   logic          presented;
   logic          grant;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop_ok;
   logic          head_owner_d;
   logic          head_discard;

   assign starved = if_req_i && (starve_q == SW'(STARVE_LIMIT));

   always_comb begin
      state_d   = state_q;
      sel_is_d  = 1'b0;
      req_pend  = 1'b0;
      presented = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            sel_is_d = d_req_i & ~starved;
            req_pend = if_req_i | d_req_i;
         end
         ARB_HOLD_IF: req_pend = if_req_i;
         ARB_HOLD_D: begin
            sel_is_d = 1'b1;
            req_pend = d_req_i;
         end
         default: ;
      endcase
      // The full check uses the registered count so a same-cycle pop never feeds back into req.
      presented = req_pend & ~fifo_full;
      case (state_q)
         ARB_IDLE: begin
            if (presented && !mem_gnt_i) begin
               state_d = sel_is_d ? ARB_HOLD_D : ARB_HOLD_IF;
            end
         end
         ARB_HOLD_IF, ARB_HOLD_D: begin
            if (presented && mem_gnt_i) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign mem_req_o = rst_n_i & presented;
   assign grant     = mem_req_o & mem_gnt_i;
   assign if_gnt_o  = grant & ~sel_is_d;
   assign d_gnt_o   = grant & sel_is_d;

   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (rst_n_i) begin
         if (sel_is_d) begin
            mem_we_o    = d_we_i;
            mem_be_o    = d_be_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
         end else begin
            mem_be_o   = '1;
            mem_addr_o = if_addr_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         starve_q <= '0;
      end else if (!if_req_i || if_gnt_o) begin
         starve_q <= '0;
      end else if (d_gnt_o && starve_q != SW'(STARVE_LIMIT)) begin
         starve_q <= starve_q + SW'(1);
      end
   end

   mem_owner_fifo #(
      .DEPTH(MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .push_i         (grant),
      .push_owner_d_i (sel_is_d),
      .push_discard_i (~sel_is_d & flush_i),
      .pop_i          (mem_rvalid_i),
      .flush_i        (flush_i),
      .head_owner_d_o (head_owner_d),
      .head_discard_o (head_discard),
      .empty_o        (fifo_empty),
      .full_o         (fifo_full)
   );

   assign pop_ok      = mem_rvalid_i & ~fifo_empty;
   assign if_rvalid_o = pop_ok & ~head_owner_d & ~head_discard;
   assign d_rvalid_o  = pop_ok & head_owner_d;
   assign if_rdata_o  = {DW{rst_n_i}} & mem_rdata_i;
   assign d_rdata_o   = {DW{rst_n_i}} & mem_rdata_i;

   a_rvalid_has_owner: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      mem_rvalid_i |-> !fifo_empty);

endmodule
